// File: rtl/debounce_timer_arbiter.sv
// Shares one delay counter between N_CH debouncer channels: round-robin grant,
// programmable settle delay, one-cycle fin pulse back to the owning channel.
module debounce_timer_arbiter #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 20,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic [CNT_W-1:0] delay_val,
    output logic [N_CH-1:0]  grant,
    output logic [N_CH-1:0]  fin,
    output logic             busy,
    output logic [ID_W-1:0]  gnt_id,
    output logic [7:0]       abort_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   r_delay;
    logic [CNT_W-1:0]   w_delay_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_ptr_next;
    logic [N_CH-1:0]    r_grant;
    logic [N_CH-1:0]    w_grant_next;
    logic [N_CH-1:0]    r_fin;
    logic [N_CH-1:0]    w_fin_next;
    logic               r_busy;
    logic               w_busy_next;
    logic [ID_W-1:0]    r_gnt_id;
    logic [ID_W-1:0]    w_gnt_id_next;
    logic [7:0]         r_abort_cnt;
    logic [7:0]         w_abort_cnt_next;

    logic [ID_W-1:0]    w_win;
    logic [N_CH-1:0]    w_win_oh;
    logic [N_CH-1:0]    w_held;
    logic               w_req_held;
    logic [ID_W-1:0]    w_ptr_after;
    logic [CNT_W-1:0]   w_delay_in;
    logic               w_cnt_last;

    // Round-robin scan: offsets are walked from farthest to nearest so the
    // channel closest to the pointer (with wrap) is the last one written.
    always_comb begin
        w_win = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            for (int j = 0; j < N_CH; j++) begin
                if (req[j] && (j == ((int'(r_ptr) + k) % N_CH))) begin
                    w_win = ID_W'(j);
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            assign w_win_oh[gi] = (w_win == ID_W'(gi));
            assign w_held[gi]   = req[gi] & r_grant[gi];
        end
    endgenerate

    assign w_req_held  = |w_held;
    assign w_ptr_after = (r_gnt_id == ID_W'(N_CH - 1)) ? '0 : r_gnt_id + ID_W'(1);
    assign w_delay_in  = (delay_val == '0) ? CNT_W'(1) : delay_val;
    assign w_cnt_last  = (r_cnt == r_delay - CNT_W'(1));

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_delay_next     = r_delay;
        w_ptr_next       = r_ptr;
        w_grant_next     = r_grant;
        w_fin_next       = '0;
        w_busy_next      = r_busy;
        w_gnt_id_next    = r_gnt_id;
        w_abort_cnt_next = r_abort_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_next  = S_COUNT;
                    w_grant_next  = w_win_oh;
                    w_gnt_id_next = w_win;
                    w_cnt_next    = '0;
                    w_delay_next  = w_delay_in;
                    w_busy_next   = 1'b1;
                end
            end
            S_COUNT: begin
                // A dropped request wins over a terminal count on the same edge.
                if (!w_req_held) begin
                    w_state_next = S_IDLE;
                    w_grant_next = '0;
                    w_busy_next  = 1'b0;
                    w_ptr_next   = w_ptr_after;
                    if (r_abort_cnt != 8'hFF) begin
                        w_abort_cnt_next = r_abort_cnt + 8'd1;
                    end
                end else if (w_cnt_last) begin
                    w_state_next = S_DONE;
                    w_fin_next   = r_grant;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_grant_next = '0;
                w_busy_next  = 1'b0;
                w_ptr_next   = w_ptr_after;
            end
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = '0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_delay     <= '0;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_fin       <= '0;
            r_busy      <= 1'b0;
            r_gnt_id    <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_delay     <= w_delay_next;
            r_ptr       <= w_ptr_next;
            r_grant     <= w_grant_next;
            r_fin       <= w_fin_next;
            r_busy      <= w_busy_next;
            r_gnt_id    <= w_gnt_id_next;
            r_abort_cnt <= w_abort_cnt_next;
        end
    end

    assign grant     = r_grant;
    assign fin       = r_fin;
    assign busy      = r_busy;
    assign gnt_id    = r_gnt_id;
    assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Scenario bench for debounce_timer_arbiter: expected fin pulses are queued at
// stimulus time and popped when the DUT pulses fin.
module tb_debounce_timer_arbiter;

    localparam int N_CH  = 4;
    localparam int CNT_W = 20;
    localparam int ID_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_CH-1:0]  req;
    logic [CNT_W-1:0] delay_val;
    logic [N_CH-1:0]  grant;
    logic [N_CH-1:0]  fin;
    logic             busy;
    logic [ID_W-1:0]  gnt_id;
    logic [7:0]       abort_cnt;

    debounce_timer_arbiter #(.N_CH(N_CH), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .delay_val(delay_val),
        .grant(grant), .fin(fin), .busy(busy), .gnt_id(gnt_id), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int ch;
        int dly;
    } exp_t;
    exp_t sb_q[$];

    // Per-cycle invariants: fin within grant, both zero or one-hot.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_total++;
            if (((fin & ~grant) != 0) || !$onehot0(grant) || !$onehot0(fin))
                $display("FAIL invariant: cyc=%0d grant=%b fin=%b", cyc, grant, fin);
            else
                n_pass++;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; delay_val = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_grant(output int e0, output bit ok);
        ok = 1'b0; e0 = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (grant != 0) begin ok = 1'b1; e0 = cyc; break; end
        end
    endtask

    task automatic wait_fin(input int bound, output int t, output bit ok);
        ok = 1'b0; t = 0;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (fin != 0) begin ok = 1'b1; t = cyc; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; delay_val = '0;
        #2;
        n_total++; if (grant !== 4'b0) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
        n_total++; if (fin !== 4'b0) $display("FAIL reset_fin: got %b want 0000", fin); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (gnt_id !== 2'd0) $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); else n_pass++;
        n_total++; if (abort_cnt !== 8'd0) $display("FAIL reset_abort_cnt: got %0d want 0", abort_cnt); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single();
        int e0, t; bit ok; exp_t e; logic [N_CH-1:0] oh;
        delay_val = 20'd5; req = 4'b0001;
        sb_q.push_back('{ch: 0, dly: 5});
        wait_grant(e0, ok);
        n_total++; if (!ok) $display("FAIL single_grant_timeout: got none want grant"); else n_pass++;
        n_total++; if (grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", grant); else n_pass++;
        n_total++; if (gnt_id !== 2'd0) $display("FAIL single_gnt_id: got %0d want 0", gnt_id); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        wait_fin(20, t, ok);
        e = sb_q.pop_front();
        oh = N_CH'(1 << e.ch);
        n_total++; if (fin !== oh) $display("FAIL single_fin: got %b want %b", fin, oh); else n_pass++;
        n_total++; if (t - e0 !== e.dly) $display("FAIL single_latency: got %0d want %0d", t - e0, e.dly); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy_done: got %b want 1", busy); else n_pass++;
        tick();
        n_total++; if (fin !== 4'b0) $display("FAIL single_fin_width: got %b want 0000", fin); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
        n_total++; if (grant !== 4'b0) $display("FAIL single_grant_end: got %b want 0000", grant); else n_pass++;
        req = '0;
        tick(); tick();
        $display("test_single: grant at %0d fin at %0d", e0, t);
    endtask

    task automatic test_round_robin();
        int t, prev; bit ok; exp_t e; logic [N_CH-1:0] oh;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        delay_val = 20'd3; req = 4'b1111;
        foreach (order[i]) sb_q.push_back('{ch: order[i], dly: 3});
        prev = 0;
        for (int r = 0; r < 5; r++) begin
            wait_fin(20, t, ok);
            e = sb_q.pop_front();
            oh = N_CH'(1 << e.ch);
            n_total++; if (fin !== oh) $display("FAIL rr_fin[%0d]: got %b want %b", r, fin, oh); else n_pass++;
            n_total++; if (gnt_id !== ID_W'(e.ch)) $display("FAIL rr_gnt_id[%0d]: got %0d want %0d", r, gnt_id, e.ch); else n_pass++;
            if (r > 0) begin
                n_total++; if (t - prev !== 5) $display("FAIL rr_spacing[%0d]: got %0d want 5", r, t - prev); else n_pass++;
            end
            $display("test_round_robin: grant %0d ch=%0d fin at %0d", r, gnt_id, t);
            prev = t;
            tick();
            n_total++; if (fin !== 4'b0) $display("FAIL rr_fin_width[%0d]: got %b want 0000", r, fin); else n_pass++;
            if (r == 4) req = '0;
        end
        tick(); tick();
    endtask

    task automatic test_zero_delay();
        int e0, t; bit ok; exp_t e; logic [N_CH-1:0] oh;
        int dly_tab[2] = '{0, 8};
        int exp_tab[2] = '{1, 8};
        do_reset();
        for (int p = 0; p < 2; p++) begin
            delay_val = CNT_W'(dly_tab[p]); req = 4'b0010;
            sb_q.push_back('{ch: 1, dly: exp_tab[p]});
            wait_grant(e0, ok);
            n_total++; if (!ok) $display("FAIL zd_grant_timeout[%0d]: got none want grant", p); else n_pass++;
            delay_val = 20'd50;
            wait_fin(80, t, ok);
            e = sb_q.pop_front();
            oh = N_CH'(1 << e.ch);
            n_total++; if (fin !== oh) $display("FAIL zd_fin[%0d]: got %b want %b", p, fin, oh); else n_pass++;
            n_total++; if (t - e0 !== e.dly) $display("FAIL zd_latency[%0d]: got %0d want %0d", p, t - e0, e.dly); else n_pass++;
            $display("test_zero_delay: delay_val=%0d fin after %0d", dly_tab[p], t - e0);
            req = '0;
            tick(); tick(); tick();
        end
    endtask

    task automatic test_abort();
        int e0; bit ok; bit fin_seen;
        do_reset();
        delay_val = 20'd10; req = 4'b0100;
        wait_grant(e0, ok);
        n_total++; if (grant !== 4'b0100) $display("FAIL abort_grant: got %b want 0100", grant); else n_pass++;
        repeat (4) tick();
        req = '0;
        tick();
        n_total++; if (grant !== 4'b0) $display("FAIL abort_grant_clr: got %b want 0000", grant); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (abort_cnt !== 8'd1) $display("FAIL abort_cnt: got %0d want 1", abort_cnt); else n_pass++;
        fin_seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (fin != 0) fin_seen = 1'b1;
            tick();
        end
        n_total++; if (fin_seen !== 1'b0) $display("FAIL abort_no_fin: got fin want none"); else n_pass++;
        req = 4'b1111;
        wait_grant(e0, ok);
        n_total++; if (gnt_id !== 2'd3) $display("FAIL abort_next_ptr: got %0d want 3", gnt_id); else n_pass++;
        n_total++; if (grant !== 4'b1000) $display("FAIL abort_next_grant: got %b want 1000", grant); else n_pass++;
        req = '0;
        tick(); tick();
        $display("test_abort: abort_cnt=%0d", abort_cnt);
    endtask

    task automatic test_async_reset();
        int e0, t; bit ok; exp_t e; logic [N_CH-1:0] oh;
        delay_val = 20'd10; req = 4'b0100;
        wait_grant(e0, ok);
        n_total++; if (gnt_id !== 2'd2) $display("FAIL ar_pre_gnt_id: got %0d want 2", gnt_id); else n_pass++;
        n_total++; if (abort_cnt !== 8'd2) $display("FAIL ar_pre_abort_cnt: got %0d want 2", abort_cnt); else n_pass++;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        n_total++; if (grant !== 4'b0) $display("FAIL ar_grant: got %b want 0000", grant); else n_pass++;
        n_total++; if (fin !== 4'b0) $display("FAIL ar_fin: got %b want 0000", fin); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (gnt_id !== 2'd0) $display("FAIL ar_gnt_id: got %0d want 0", gnt_id); else n_pass++;
        n_total++; if (abort_cnt !== 8'd0) $display("FAIL ar_abort_cnt: got %0d want 0", abort_cnt); else n_pass++;
        tick();
        rst = 1'b0; req = 4'b1111; delay_val = 20'd3;
        sb_q.push_back('{ch: 0, dly: 3});
        wait_grant(e0, ok);
        n_total++; if (grant !== 4'b0001) $display("FAIL ar_restart_grant: got %b want 0001", grant); else n_pass++;
        wait_fin(20, t, ok);
        e = sb_q.pop_front();
        oh = N_CH'(1 << e.ch);
        n_total++; if (fin !== oh) $display("FAIL ar_restart_fin: got %b want %b", fin, oh); else n_pass++;
        n_total++; if (t - e0 !== e.dly) $display("FAIL ar_restart_latency: got %0d want %0d", t - e0, e.dly); else n_pass++;
        req = '0;
        tick(); tick();
        $display("test_async_reset: restart grant at %0d fin at %0d", e0, t);
    endtask

    task automatic test_saturation();
        int e0; bit ok; int exp_cnt;
        do_reset();
        delay_val = 20'd20;
        exp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            req = 4'b0001;
            wait_grant(e0, ok);
            if (!ok) begin
                n_total++;
                $display("FAIL sat_grant_timeout: got none want grant at abort %0d", i);
                break;
            end
            req = '0;
            tick();
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            if (i == 9 || i == 254 || i == 299) begin
                n_total++;
                if (abort_cnt !== 8'(exp_cnt)) $display("FAIL sat_abort_cnt[%0d]: got %0d want %0d", i, abort_cnt, exp_cnt);
                else n_pass++;
                $display("test_saturation: after %0d aborts abort_cnt=%0d", i + 1, abort_cnt);
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_delay();
        test_abort();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
